alu_pipe: RTL and testbench

Width-parametrised, handshaked successor to the 8-bit combinational ALU in the datapath. It registers its result and keeps a persistent Z/C/N/O flag register with a write enable. It adds multi-bit shifts and rotates, executed iteratively one bit per cycle. It sits between the register-file read ports and the write-back mux, and a controller drives it with a valid/ready handshake.

---
 rtl/alu_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with a persistent {Z,C,N,O} flag
// register. Single-cycle ops complete at the accept edge; multi-bit shifts
// and rotates iterate one bit per cycle in the SHIFT state.
//
//   state | meaning
//   IDLE  | ready for a new op; single-cycle ops and shifts by 0/1 finish here
//   SHIFT | iterating a shift/rotate by k>=2, one bit per edge, cnt counts down
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             flag_we,
  output logic [WIDTH-1:0] OutALU,
  output logic [3:0]       Flags,
  output logic             out_valid
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_NA   = 4'b0010;
  localparam logic [3:0] OP_NB   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_NAND = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_LSL  = 4'b1011;
  localparam logic [3:0] OP_LSR  = 4'b1100;
  localparam logic [3:0] OP_ASL  = 4'b1101;
  localparam logic [3:0] OP_ASR  = 4'b1110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [3:0]       op_q, op_d;
  logic             fwe_q, fwe_d;
  logic             o_sh_q, o_sh_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  // completion bundle shared by the IDLE and SHIFT paths
  logic             done;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_o, fin_upd_c, fin_upd_o, fin_upd_out, fin_we;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   step_v;
  logic [SHW-1:0]   k;
  logic             o_next;

  // One shift/rotate step: returns {bit shifted out, new value}
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] op,
                                                input logic [WIDTH-1:0] v);
    case (op)
      OP_LSL, OP_ASL: shift_step = {v[MSB], v[MSB-1:0], 1'b0};
      OP_LSR:         shift_step = {v[0], 1'b0, v[MSB:1]};
      OP_ASR:         shift_step = {v[0], v[MSB], v[MSB:1]};
      default:        shift_step = {v[0], v[0], v[MSB:1]};
    endcase
  endfunction

  // Next-state, datapath and completion logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    op_d        = op_q;
    fwe_d       = fwe_q;
    o_sh_d      = o_sh_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    done        = 1'b0;
    fin_res     = '0;
    fin_c       = 1'b0;
    fin_o       = 1'b0;
    fin_upd_c   = 1'b0;
    fin_upd_o   = 1'b0;
    fin_upd_out = 1'b1;
    fin_we      = flag_we;
    sum         = '0;
    step_v      = '0;
    k           = B[SHW-1:0];
    o_next      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (FunSel < OP_LSL) begin
            done = 1'b1;
            case (FunSel)
              OP_A:    fin_res = A;
              OP_B:    fin_res = B;
              OP_NA:   fin_res = ~A;
              OP_NB:   fin_res = ~B;
              OP_ADD: begin
                sum       = {1'b0, A} + {1'b0, B};
                fin_res   = sum[MSB:0];
                fin_c     = sum[WIDTH];
                fin_o     = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
                fin_upd_c = 1'b1;
                fin_upd_o = 1'b1;
              end
              OP_SUB, OP_CMP: begin
                sum         = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                fin_res     = sum[MSB:0];
                fin_c       = sum[WIDTH];
                fin_o       = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
                fin_upd_c   = 1'b1;
                fin_upd_o   = 1'b1;
                fin_upd_out = (FunSel != OP_CMP);
              end
              OP_AND:  fin_res = A & B;
              OP_OR:   fin_res = A | B;
              OP_NAND: fin_res = ~(A & B);
              default: fin_res = A ^ B;
            endcase
          end else begin
            step_v = shift_step(FunSel, A);
            if (k == '0) begin
              // pass-through: only Z/N can change
              done    = 1'b1;
              fin_res = A;
            end else if (k == SHW'(1)) begin
              done      = 1'b1;
              fin_res   = step_v[MSB:0];
              fin_c     = step_v[WIDTH];
              fin_upd_c = 1'b1;
              fin_upd_o = (FunSel == OP_ASL);
              fin_o     = step_v[MSB] != A[MSB];
            end else begin
              work_d  = step_v[MSB:0];
              o_sh_d  = step_v[MSB] != A[MSB];
              cnt_d   = k - SHW'(1);
              op_d    = FunSel;
              fwe_d   = flag_we;
              state_d = SHIFT;
            end
          end
        end
      end
      default: begin
        step_v = shift_step(op_q, work_q);
        o_next = o_sh_q | (step_v[MSB] != work_q[MSB]);
        work_d = step_v[MSB:0];
        o_sh_d = o_next;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          done      = 1'b1;
          fin_res   = step_v[MSB:0];
          fin_c     = step_v[WIDTH];
          fin_upd_c = 1'b1;
          fin_upd_o = (op_q == OP_ASL);
          fin_o     = o_next;
          fin_we    = fwe_q;
          state_d   = IDLE;
        end
      end
    endcase

    if (done) begin
      out_valid_d = 1'b1;
      if (fin_upd_out) out_d = fin_res;
      if (fin_we) begin
        flags_d[3] = (fin_res == '0);
        flags_d[1] = fin_res[MSB];
        if (fin_upd_c) flags_d[2] = fin_c;
        if (fin_upd_o) flags_d[0] = fin_o;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      op_q        <= '0;
      fwe_q       <= 1'b0;
      o_sh_q      <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      op_q        <= op_d;
      fwe_q       <= fwe_d;
      o_sh_q      <= o_sh_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign OutALU    = out_q;
  assign Flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int MAXS = (1 << (W-1)) - 1;
  localparam int MINS = -(1 << (W-1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   FunSel = '0;
  logic         flag_we = 1'b0;
  logic [W-1:0] OutALU;
  logic [3:0]   Flags;
  logic         out_valid;

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_out = '0;
  logic [3:0]   m_flags = '0;
  int           m_lat = 1;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FunSel(FunSel), .flag_we(flag_we),
    .OutALU(OutALU), .Flags(Flags), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: result, flags and latency from arithmetic definitions
  function automatic void ref_step(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic we);
    int k, s;
    logic [W-1:0] r;
    logic signed [W-1:0] sa;
    logic c, o;
    k = int'(b) % W;
    sa = a;
    r = '0;
    c = m_flags[2];
    o = m_flags[0];
    case (op)
      4'd0: r = a;
      4'd1: r = b;
      4'd2: r = ~a;
      4'd3: r = ~b;
      4'd4: begin
        r = a + b;
        c = (int'(a) + int'(b)) >= (1 << W);
        s = int'(sa) + int'($signed(b));
        o = (s > MAXS) || (s < MINS);
      end
      4'd5, 4'd6: begin
        r = a - b;
        c = (a >= b);
        s = int'(sa) - int'($signed(b));
        o = (s > MAXS) || (s < MINS);
      end
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = ~(a & b);
      4'd10: r = a ^ b;
      4'd11, 4'd13: begin
        r = a << k;
        if (k > 0) c = a[W-k];
        if (op == 4'd13 && k > 0) begin
          o = 1'b0;
          for (int j = 1; j <= k; j++) if (a[W-1-j] != a[W-1]) o = 1'b1;
        end
      end
      4'd12: begin r = a >> k; if (k > 0) c = a[k-1]; end
      4'd14: begin r = sa >>> k; if (k > 0) c = a[k-1]; end
      default: begin r = (a >> k) | (a << (W-k)); if (k > 0) c = a[k-1]; end
    endcase
    if (we) m_flags = {(r == '0), c, r[W-1], o};
    if (op != 4'd6) m_out = r;
    m_lat = (op >= 4'd11 && k >= 2) ? k : 1;
  endfunction

  // Drive one op from a negedge with in_ready high; returns at the negedge
  // where out_valid is seen (lat = cycles after accept, -1 on timeout)
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic we,
                       output int lat, output int busy);
    in_valid = 1'b1; FunSel = op; A = a; B = b; flag_we = we;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = -1; busy = 0;
    for (int i = 1; i <= 2*W + 4; i++) begin
      if (out_valid) begin lat = i; break; end
      if (!in_ready) busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; FunSel = 4'd4; A = 8'h01; B = 8'h01; flag_we = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    total++; if (OutALU !== '0) begin bad++; $display("FAIL reset_out got=%h exp=00", OutALU); end
    total++; if (Flags !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_ov got=%b exp=0", out_valid); end
  endtask

  typedef struct {logic [3:0] op; logic [W-1:0] a, b; logic we;
                  logic [W-1:0] eo; logic [3:0] ef; int el;} vec_t;

  task automatic run_table(input string name, input vec_t v[]);
    int lat, busy;
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].we, lat, busy);
      ref_step(v[i].op, v[i].a, v[i].b, v[i].we);
      total++; if (lat !== v[i].el) begin bad++; $display("FAIL %s[%0d]_lat got=%0d exp=%0d", name, i, lat, v[i].el); end
      total++; if (OutALU !== v[i].eo) begin bad++; $display("FAIL %s[%0d]_out got=%h exp=%h", name, i, OutALU, v[i].eo); end
      total++; if (Flags !== v[i].ef) begin bad++; $display("FAIL %s[%0d]_flags got=%b exp=%b", name, i, Flags, v[i].ef); end
    end
  endtask

  task automatic test_arith();
    vec_t v[];
    v = '{'{4'd4, 8'h33, 8'h0F, 1'b1, 8'h42, 4'b0000, 1},
          '{4'd4, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011, 1},
          '{4'd6, 8'h40, 8'h38, 1'b1, 8'h80, 4'b0100, 1},
          '{4'd5, 8'h07, 8'hFA, 1'b1, 8'h0D, 4'b0000, 1},
          '{4'd4, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0000, 1}};
    run_table("arith", v);
  endtask

  task automatic test_shift_busy();
    in_valid = 1'b1; FunSel = 4'd11; A = 8'h33; B = 8'h03; flag_we = 1'b1;
    ref_step(4'd11, 8'h33, 8'h03, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready1 got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_ov1 got=%b exp=0", out_valid); end
    in_valid = 1'b1; FunSel = 4'd4; A = 8'h01; B = 8'h01;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready2 got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_ov2 got=%b exp=0", out_valid); end
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL busy_ov3 got=%b exp=1", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL busy_ready3 got=%b exp=1", in_ready); end
    total++; if (OutALU !== 8'h98) begin bad++; $display("FAIL lsl_out got=%h exp=98", OutALU); end
    total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL lsl_flags got=%b exp=0110", Flags); end
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_ignored_ov got=%b exp=0", out_valid); end
    total++; if (OutALU !== m_out) begin bad++; $display("FAIL busy_hold_out got=%h exp=%h", OutALU, m_out); end
  endtask

  task automatic test_shift();
    vec_t v[];
    v = '{'{4'd15, 8'h81, 8'h01, 1'b1, 8'hC0, 4'b0110, 1},
          '{4'd13, 8'h40, 8'h02, 1'b1, 8'h00, 4'b1101, 2}};
    run_table("shift", v);
  endtask

  task automatic test_reset_mid_shift();
    int lat, busy;
    in_valid = 1'b1; FunSel = 4'd14; A = 8'h80; B = 8'h07; flag_we = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_ov1 got=%b exp=0", out_valid); end
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_ov2 got=%b exp=0", out_valid); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_out = '0; m_flags = '0;
    total++; if (OutALU !== '0) begin bad++; $display("FAIL abort_out got=%h exp=00", OutALU); end
    total++; if (Flags !== 4'b0) begin bad++; $display("FAIL abort_flags got=%b exp=0000", Flags); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_ov[%0d] got=%b exp=0", i, out_valid); end
    end
    do_op(4'd4, 8'h01, 8'h01, 1'b1, lat, busy);
    ref_step(4'd4, 8'h01, 8'h01, 1'b1);
    total++; if (lat !== 1) begin bad++; $display("FAIL post_abort_lat got=%0d exp=1", lat); end
    total++; if (OutALU !== 8'h02) begin bad++; $display("FAIL post_abort_out got=%h exp=02", OutALU); end
  endtask

  task automatic test_random();
    int lat, busy;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic we;
    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15));
      a = W'($urandom); b = W'($urandom);
      we = ($urandom_range(0, 3) != 0);
      do_op(op, a, b, we, lat, busy);
      ref_step(op, a, b, we);
      total++; if (lat !== m_lat) begin bad++; $display("FAIL rnd[%0d]_lat op=%0d got=%0d exp=%0d", i, op, lat, m_lat); end
      total++; if (busy !== m_lat - 1) begin bad++; $display("FAIL rnd[%0d]_busy op=%0d got=%0d exp=%0d", i, op, busy, m_lat - 1); end
      total++; if (OutALU !== m_out) begin bad++; $display("FAIL rnd[%0d]_out op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, OutALU, m_out); end
      total++; if (Flags !== m_flags) begin bad++; $display("FAIL rnd[%0d]_flags op=%0d a=%h b=%h we=%b got=%b exp=%b", i, op, a, b, we, Flags, m_flags); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic we;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 10));
      a = W'($urandom); b = W'($urandom); we = $urandom_range(0, 1) != 0;
      in_valid = 1'b1; FunSel = op; A = a; B = b; flag_we = we;
      ref_step(op, a, b, we);
      @(posedge clk); @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b[%0d]_ov got=%b exp=1", i, out_valid); end
      total++; if (OutALU !== m_out) begin bad++; $display("FAIL b2b[%0d]_out got=%h exp=%h", i, OutALU, m_out); end
      total++; if (Flags !== m_flags) begin bad++; $display("FAIL b2b[%0d]_flags got=%b exp=%b", i, Flags, m_flags); end
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_ov got=%b exp=0", out_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_shift_busy();
    test_shift();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
